demux_one_to_two_stream: RTL and testbench

- Registered 1-to-2 stream demultiplexer: the routing counterpart to the 2-to-1 data mux.
- Accepts one N_BITS word per valid/ready handshake on a single input and routes it to output channel 0 or 1 according to Selector.
- Each output has a one-entry holding register with its own valid/ready handshake, so a stalled channel never blocks traffic to the other.
- Keeps a per-channel delivered-word counter for debug and verification.

---
 rtl/demux_one_to_two_stream.sv | 145 ++++++++++++++
 tb/tb_demux_one_to_two_stream.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/demux_one_to_two_stream.sv
// ---------------------------------------------------------------------------
// demux_one_to_two_stream
//
// Registered 1-to-2 stream demultiplexer. One word is accepted per
// valid/ready handshake on the input and routed to channel 0 or 1 according
// to Selector. Each output channel owns a one-entry holding register with its
// own handshake, so a stalled channel never blocks traffic to the other.
// A per-channel counter records how many words each channel has delivered.
//
// Handshake semantics (input and both outputs): a transfer happens on a rising
// clk edge where valid and ready are both 1. A producer keeps valid and data
// stable until the transfer; ready may depend combinationally on the far side.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   reset        asynchronous, active-high reset
//   Selector     route for the current input word (0 -> ch0, 1 -> ch1)
//   In_Valid     In_Data holds a valid word
//   In_Data      input word
//   In_Ready     block accepts the word this cycle (combinational)
//   Out_Valid_x  channel x holding register is full
//   Out_Data_x   channel x word
//   Out_Ready_x  channel x consumer accepts the word
//   Count_x      words delivered on channel x (wraps silently)
// ---------------------------------------------------------------------------
module demux_one_to_two_stream #(
    parameter int N_BITS     = 8,
    parameter int COUNT_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Selector,
    input  logic                  In_Valid,
    input  logic [N_BITS-1:0]     In_Data,
    output logic                  In_Ready,
    output logic                  Out_Valid_0,
    output logic [N_BITS-1:0]     Out_Data_0,
    input  logic                  Out_Ready_0,
    output logic                  Out_Valid_1,
    output logic [N_BITS-1:0]     Out_Data_1,
    input  logic                  Out_Ready_1,
    output logic [COUNT_BITS-1:0] Count_0,
    output logic [COUNT_BITS-1:0] Count_1
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } chan_state_t;

    // Per-channel holding-register state; Out_Valid_x is a direct decode of it.
    chan_state_t state_q [2];
    chan_state_t state_d [2];

    logic [N_BITS-1:0]     data_q [2];
    logic [COUNT_BITS-1:0] count_q [2];

    logic [1:0] out_ready;
    logic [1:0] out_valid;
    logic [1:0] load;
    logic [1:0] drain;

    assign out_ready = {Out_Ready_1, Out_Ready_0};

    // A channel can take a word when it is empty or is being drained this
    // cycle; only the selected channel matters, so a stalled peer never
    // holds up the input.
    assign In_Ready = Selector ? (!out_valid[1] || out_ready[1])
                               : (!out_valid[0] || out_ready[0]);

    always_comb begin
        load  = '0;
        drain = '0;
        for (int c = 0; c < 2; c++) begin
            drain[c] = out_valid[c] && out_ready[c];
        end
        load[0] = In_Valid && In_Ready && !Selector;
        load[1] = In_Valid && In_Ready &&  Selector;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q[0] <= S_EMPTY;
            state_q[1] <= S_EMPTY;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
        end
    end

    // Next-state logic: a load always leaves the channel full (load wins over
    // a simultaneous drain); a drain without a load empties it.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            state_d[c] = state_q[c];
            case (state_q[c])
                S_EMPTY: if (load[c])       state_d[c] = S_FULL;
                S_FULL:  if (load[c])       state_d[c] = S_FULL;
                         else if (drain[c]) state_d[c] = S_EMPTY;
                default:                    state_d[c] = S_EMPTY;
            endcase
        end
    end

    // Output decode
    always_comb begin
        out_valid   = '0;
        for (int c = 0; c < 2; c++) begin
            out_valid[c] = (state_q[c] == S_FULL);
        end
        Out_Valid_0 = out_valid[0];
        Out_Valid_1 = out_valid[1];
        Out_Data_0  = data_q[0];
        Out_Data_1  = data_q[1];
        Count_0     = count_q[0];
        Count_1     = count_q[1];
    end

    // Holding data only changes on a load, so it stays stable while stalled
    // and keeps its last value once drained.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (load[c]) data_q[c] <= In_Data;
            end
        end
    end

    // Delivered-word counters, free-running wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q[0] <= '0;
            count_q[1] <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (drain[c]) count_q[c] <= count_q[c] + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_demux_one_to_two_stream.sv
module tb_demux_one_to_two_stream;

    localparam int N_BITS     = 8;
    localparam int COUNT_BITS = 8;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  Selector;
    logic                  In_Valid;
    logic [N_BITS-1:0]     In_Data;
    logic                  In_Ready;
    logic                  Out_Valid_0;
    logic [N_BITS-1:0]     Out_Data_0;
    logic                  Out_Ready_0;
    logic                  Out_Valid_1;
    logic [N_BITS-1:0]     Out_Data_1;
    logic                  Out_Ready_1;
    logic [COUNT_BITS-1:0] Count_0;
    logic [COUNT_BITS-1:0] Count_1;

    demux_one_to_two_stream #(
        .N_BITS(N_BITS),
        .COUNT_BITS(COUNT_BITS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .Selector(Selector),
        .In_Valid(In_Valid),
        .In_Data(In_Data),
        .In_Ready(In_Ready),
        .Out_Valid_0(Out_Valid_0),
        .Out_Data_0(Out_Data_0),
        .Out_Ready_0(Out_Ready_0),
        .Out_Valid_1(Out_Valid_1),
        .Out_Data_1(Out_Data_1),
        .Out_Ready_1(Out_Ready_1),
        .Count_0(Count_0),
        .Count_1(Count_1)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard / reference model ----------------
    // Each channel is modelled as an in-order queue of accepted words that
    // the consumer has not yet taken; delivered-word counts are plain integers.
    logic [N_BITS-1:0] exp_q0[$];
    logic [N_BITS-1:0] exp_q1[$];
    logic [N_BITS-1:0] last_0, last_1;
    int unsigned       delivered_0, delivered_1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q0.delete();
        exp_q1.delete();
        last_0      = '0;
        last_1      = '0;
        delivered_0 = 0;
        delivered_1 = 0;
    endtask

    task automatic check_outputs();
        check("out_valid_0", 32'(Out_Valid_0), 32'(exp_q0.size() != 0));
        check("out_valid_1", 32'(Out_Valid_1), 32'(exp_q1.size() != 0));
        check("out_data_0",  32'(Out_Data_0),  32'(last_0));
        check("out_data_1",  32'(Out_Data_1),  32'(last_1));
        check("count_0",     32'(Count_0),     32'(delivered_0 % (1 << COUNT_BITS)));
        check("count_1",     32'(Count_1),     32'(delivered_1 % (1 << COUNT_BITS)));
    endtask

    // ---------------- driver ----------------
    // Called just after a rising edge: drives one cycle of inputs, checks the
    // DUT at the falling edge, then advances the model across the next edge.
    task automatic step(input logic sel, input logic vld, input logic [N_BITS-1:0] d,
                        input logic r0, input logic r1);
        logic full0, full1, exp_rdy;
        Selector    = sel;
        In_Valid    = vld;
        In_Data     = d;
        Out_Ready_0 = r0;
        Out_Ready_1 = r1;
        @(negedge clk);
        full0   = (exp_q0.size() != 0);
        full1   = (exp_q1.size() != 0);
        exp_rdy = sel ? (!full1 || r1) : (!full0 || r0);
        check_outputs();
        check("in_ready", 32'(In_Ready), 32'(exp_rdy));
        @(posedge clk);
        if (full0 && r0) begin
            void'(exp_q0.pop_front());
            delivered_0++;
        end
        if (full1 && r1) begin
            void'(exp_q1.pop_front());
            delivered_1++;
        end
        if (vld && exp_rdy) begin
            if (sel) begin
                exp_q1.push_back(d);
                last_1 = d;
            end else begin
                exp_q0.push_back(d);
                last_0 = d;
            end
        end
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset       = 1'b1;
        Selector    = 1'b0;
        In_Valid    = 1'b1;
        In_Data     = 8'hA5;
        Out_Ready_0 = 1'b0;
        Out_Ready_1 = 1'b0;
        model_clear();

        // Reset with a valid word presented: nothing captured, ready reads 1.
        repeat (2) begin
            @(negedge clk);
            check_outputs();
            check("in_ready_rst", 32'(In_Ready), 32'd1);
        end
        @(posedge clk);
        #1;
        In_Valid = 1'b0;
        reset    = 1'b0;

        // Single word to ch0, drained immediately.
        step(1'b0, 1'b1, 8'h3C, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        // Stall ch1, then redirect the blocked word to ch0.
        step(1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // Back-to-back stream on ch1.
        for (int i = 1; i <= 16; i++) step(1'b1, 1'b1, 8'(i), 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);

        // Interleaved routing with both channels draining together.
        for (int i = 0; i < 4; i++) step(1'(i), 1'b1, 8'(8'h40 + i), 1'b1, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // Counter wrap on ch0: 257 more deliveries.
        for (int i = 0; i < 257; i++) step(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        // Reset mid-transfer discards held words at once.
        step(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h66, 1'b0, 1'b0);
        reset = 1'b1;
        #2;
        model_clear();
        check_outputs();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0),
                 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 2) != 0));
        end
        // Drain what is left.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
